qspi_ctrl_req_arbiter: RTL and testbench
========================================

# qspi_ctrl_req_arbiter

Control-level front end of the QSPI controller. It sits directly downstream of `qspi_interface_level` and arbitrates between the data-channel (AXI-derived) and control-channel (AHB CSR-derived) request ports. It inserts an automatic WREN (0x06) ahead of program/erase/status-write instructions and issues one instruction at a time to the transfer level. It returns completion/error responses to the control channel and publishes the in-flight label, valid and write-enable status back to the interface level.

## Interface
- `TIMEOUT_CYCLES`, 65535: cycles allowed in a wait state before abort; counter width 16 bits.
- `clock` input 1: single clock.
- `reset` input 1: synchronous, active-high.
- `io_dchan_req_valid/ready` in/out 1: data-channel request handshake.
- `io_dchan_req_data_size`, `io_dchan_req_data_burstlen`, `io_dchan_req_inst` in 8 each; `io_dchan_req_addr` in 24.
- `io_cchan_req_valid/ready` in/out 1: control-channel request handshake.
- `io_cchan_req_data_size`, `io_cchan_req_data_burstlen`, `io_cchan_req_inst` in 8 each; `io_cchan_req_addr` in 24.
- `io_tdata_lock` in 1: dchan write data still being collected; blocks dchan grant.
- `io_cchan_resp_valid` out 1: one-cycle pulse at end of every cchan op.
- `io_cchan_resp_error` out 1: qualifies resp.
- `io_cchan_resp_cause` out 2: cause code.
- `io_tran_req_valid/ready` out/in 1: issue handshake to transfer level.
- `io_tran_req_inst`, `io_tran_req_size`, `io_tran_req_burstlen` out 8 each; `io_tran_req_addr` out 24.
- `io_tran_done` in 1: transfer-level completion pulse.
- `io_tran_error` in 1: qualifies `io_tran_done`.
- `io_ctrl_lev_inst_label` out 1: channel of in-flight op; 0 = dchan, 1 = cchan.
- `io_ctrl_lev_inst_valid` out 1: op in flight.
- `io_ctrl_lev_wr_en` out 1: one-cycle pulse when WREN completes without error.

## Operation
- States:
  - IDLE
  - WREN_REQ: tran_req_valid with inst 0x06, size 0, burstlen 0, addr 0.
  - WREN_WAIT
  - CMD_REQ: tran_req_valid with latched fields.
  - CMD_WAIT
  - RESP: one cycle; cchan response only.
- Eligibility:
  - dchan is eligible when `io_dchan_req_valid && !io_tdata_lock`.
  - cchan is eligible when `io_cchan_req_valid`.
- Grant:
  - Only one eligible: that channel wins.
  - Both eligible: round-robin against `last_grant`, granting the channel not granted last.
- `ready` for the winner is asserted combinationally in IDLE only; the loser's `ready` is 0. Acceptance occurs on `valid && ready`; all request fields and the label are latched.
- Needs-WREN set, in package: 0x02, 0x32, 0x20, 0x52, 0xD8, 0xC7, 0x60, 0x01.
  - Latched inst in the set: IDLE → WREN_REQ.
  - Otherwise: IDLE → CMD_REQ.
- Transitions:
  - *_REQ → *_WAIT on `io_tran_req_ready`.
  - WREN_WAIT, done without error: pulse `wr_en`, then → CMD_REQ.
  - WREN_WAIT, done with error: cause 2'b11, and CMD is skipped.
  - CMD_WAIT, done: cause 2'b10 on error, otherwise 2'b00.
- Timeout:
  - A 16-bit counter clears on entry to any WAIT state and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES`: cause 2'b01, op aborted.
- End of op:
  - cchan op → RESP (`resp_valid` = 1, `resp_error` = (cause != 0)) → IDLE.
  - dchan op → IDLE directly; errors are dropped, and the dchan path reports via the transfer level.
- `io_ctrl_lev_inst_valid` is 1 in every non-IDLE state; the label is held stable while valid.

## Timing
- Reset values:
  - state IDLE, `last_grant` = dchan (so cchan wins the first tie).
  - All outputs 0, including the tran fields.
  - Counter 0.
- Reset mid-operation: abort to IDLE next cycle with no response pulse; the transfer level is reset by the same signal.
- Outputs: all registered except the two `req_ready` signals.
- Latency:
  - Acceptance to `io_tran_req_valid` = 1 cycle.
  - Done to RESP pulse = 1 cycle.
  - WREN done to CMD_REQ valid = 1 cycle, concurrent with the `wr_en` pulse.
- Transfer-level request fields are stable while `io_tran_req_valid` is high and not ready; valid never drops before ready.
- `io_tran_done` outside a WAIT state is ignored.
- Done and timeout in the same cycle: done wins.
- `io_tdata_lock` rising after a dchan grant has no effect on that op.

## Structure
- Package `qspi_ctrl_pkg`:
  - state enum
  - cause codes: OK = 0, TIMEOUT = 1, TRAN_ERR = 2, WREN_ERR = 3
  - INST_WREN = 8'h06
  - needs-WREN instruction constants and `needs_wren()` function
- Natural sub-module: `qspi_rr_arb2`, a two-requester round-robin arbiter with `last_grant` register, updated on accept.

## Test plan
- cchan inst 0x05 (read status) alone → tran_req 0x05 1 cycle after accept; done without error → `resp_valid` pulse, cause 0, `wr_en` never pulses.
- dchan inst 0x02 addr 0x001000 → tran sees 0x06 then 0x02 / 0x001000; `wr_en` pulses once, between the two; no cchan response.
- Both valid every cycle from reset → grants alternate cchan, dchan, cchan, dchan; neither starved over 8 ops.
- `io_tdata_lock` = 1 with both valid → cchan granted repeatedly; drop lock → next tie grants dchan.
- cchan 0xD8 with WREN done + error → no 0x D8 issued, resp error, cause 2'b11; cchan 0x9F with no done and `TIMEOUT_CYCLES` = 16 → resp error, cause 2'b01 exactly 16 cycles after entering CMD_WAIT.
- `reset` asserted in CMD_WAIT with `tran_req_ready` held low → next cycle all outputs 0, IDLE; the following cchan request is accepted normally.

Source files
------------

// File: rtl/qspi_ctrl_req_arbiter_pkg.sv
// Shared types and constants for the QSPI control-level request arbiter.
// Latency: n/a (package).
// Backpressure: n/a (package).
package qspi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WREN_REQ,
    ST_WREN_WAIT,
    ST_CMD_REQ,
    ST_CMD_WAIT,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_OK       = 2'd0,
    CAUSE_TIMEOUT  = 2'd1,
    CAUSE_TRAN_ERR = 2'd2,
    CAUSE_WREN_ERR = 2'd3
  } cause_t;

  // Channel labels as published to the interface level.
  localparam logic CHAN_DCHAN = 1'b0;
  localparam logic CHAN_CCHAN = 1'b1;

  localparam logic [7:0] INST_WREN = 8'h06;

  // Instructions that modify flash contents or status and so need WREN first.
  localparam logic [7:0] INST_PP      = 8'h02;
  localparam logic [7:0] INST_QPP     = 8'h32;
  localparam logic [7:0] INST_SE      = 8'h20;
  localparam logic [7:0] INST_BE32K   = 8'h52;
  localparam logic [7:0] INST_BE64K   = 8'hD8;
  localparam logic [7:0] INST_CE      = 8'hC7;
  localparam logic [7:0] INST_CE_ALT  = 8'h60;
  localparam logic [7:0] INST_WRSR    = 8'h01;

  typedef struct packed {
    logic [7:0]  inst;
    logic [7:0]  size;
    logic [7:0]  burstlen;
    logic [23:0] addr;
  } req_t;

  function automatic logic needs_wren(input logic [7:0] inst);
    case (inst)
      INST_PP, INST_QPP, INST_SE, INST_BE32K,
      INST_BE64K, INST_CE, INST_CE_ALT, INST_WRSR: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/qspi_ctrl_req_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; a tie goes to the requester not granted last.
// Latency: grant is combinational from requests; last_grant updates on the granting edge.
// Backpressure: grants only while enabled; a grant is an accept since requests are already valid.
module qspi_rr_arb2
  import qspi_ctrl_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic req_d,
  input  logic req_c,
  output logic gnt_d,
  output logic gnt_c
);

  logic last_grant;

  // Pick the winner; on a tie favour the channel that did not win last time.
  always_comb begin
    gnt_d = 1'b0;
    gnt_c = 1'b0;
    if (enable) begin
      if (req_d && req_c) begin
        if (last_grant == CHAN_CCHAN) gnt_d = 1'b1;
        else                          gnt_c = 1'b1;
      end else begin
        gnt_d = req_d;
        gnt_c = req_c;
      end
    end
  end

  // Remember who was granted; reset to dchan so cchan wins the first tie.
  always_ff @(posedge clock) begin
    if (reset)      last_grant <= CHAN_DCHAN;
    else if (gnt_c) last_grant <= CHAN_CCHAN;
    else if (gnt_d) last_grant <= CHAN_DCHAN;
  end

endmodule

// File: rtl/qspi_ctrl_req_arbiter.sv
// Arbitrates dchan/cchan requests, inserts WREN before writes, issues one op at a time.
// Latency: accept -> tran_req_valid 1 cycle; tran_done -> cchan response 1 cycle.
// Backpressure: request ready only in IDLE; tran request held until tran_req_ready.
module qspi_ctrl_req_arbiter
  import qspi_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_dchan_req_valid,
  output logic        io_dchan_req_ready,
  input  logic [7:0]  io_dchan_req_data_size,
  input  logic [7:0]  io_dchan_req_data_burstlen,
  input  logic [7:0]  io_dchan_req_inst,
  input  logic [23:0] io_dchan_req_addr,
  input  logic        io_cchan_req_valid,
  output logic        io_cchan_req_ready,
  input  logic [7:0]  io_cchan_req_data_size,
  input  logic [7:0]  io_cchan_req_data_burstlen,
  input  logic [7:0]  io_cchan_req_inst,
  input  logic [23:0] io_cchan_req_addr,
  input  logic        io_tdata_lock,
  output logic        io_cchan_resp_valid,
  output logic        io_cchan_resp_error,
  output logic [1:0]  io_cchan_resp_cause,
  output logic        io_tran_req_valid,
  input  logic        io_tran_req_ready,
  output logic [7:0]  io_tran_req_inst,
  output logic [7:0]  io_tran_req_size,
  output logic [7:0]  io_tran_req_burstlen,
  output logic [23:0] io_tran_req_addr,
  input  logic        io_tran_done,
  input  logic        io_tran_error,
  output logic        io_ctrl_lev_inst_label,
  output logic        io_ctrl_lev_inst_valid,
  output logic        io_ctrl_lev_wr_en
);

  // Abort fires on the wait cycle whose increment would reach TIMEOUT_CYCLES.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam req_t WREN_REQ = '{inst: INST_WREN, size: 8'h00, burstlen: 8'h00, addr: 24'h0};

  state_t      state;
  req_t        cur_req, tran_q, dchan_req, cchan_req, sel_req;
  logic        label_q, inst_valid_q, tran_vld_q, resp_vld_q, resp_err_q, wr_en_q;
  cause_t      resp_cause_q, end_cause;
  logic        end_op;
  logic [15:0] wait_cnt;
  logic        gnt_d, gnt_c;

  assign dchan_req = '{inst: io_dchan_req_inst, size: io_dchan_req_data_size,
                       burstlen: io_dchan_req_data_burstlen, addr: io_dchan_req_addr};
  assign cchan_req = '{inst: io_cchan_req_inst, size: io_cchan_req_data_size,
                       burstlen: io_cchan_req_data_burstlen, addr: io_cchan_req_addr};
  assign sel_req   = gnt_c ? cchan_req : dchan_req;

  qspi_rr_arb2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .enable (state == ST_IDLE),
    .req_d  (io_dchan_req_valid && !io_tdata_lock),
    .req_c  (io_cchan_req_valid),
    .gnt_d  (gnt_d),
    .gnt_c  (gnt_c)
  );

  // Decide whether the current wait ends the op and with which cause; done beats timeout.
  always_comb begin
    end_op    = 1'b0;
    end_cause = CAUSE_OK;
    case (state)
      ST_WREN_WAIT: begin
        if (io_tran_done) begin
          if (io_tran_error) begin
            end_op    = 1'b1;
            end_cause = CAUSE_WREN_ERR;
          end
        end else if (wait_cnt == TIMEOUT_LAST) begin
          end_op    = 1'b1;
          end_cause = CAUSE_TIMEOUT;
        end
      end
      ST_CMD_WAIT: begin
        if (io_tran_done) begin
          end_op    = 1'b1;
          end_cause = io_tran_error ? CAUSE_TRAN_ERR : CAUSE_OK;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          end_op    = 1'b1;
          end_cause = CAUSE_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  // Control FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      cur_req      <= '0;
      tran_q       <= '0;
      label_q      <= CHAN_DCHAN;
      inst_valid_q <= 1'b0;
      tran_vld_q   <= 1'b0;
      resp_vld_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_cause_q <= CAUSE_OK;
      wr_en_q      <= 1'b0;
      wait_cnt     <= 16'd0;
    end else begin
      resp_vld_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_cause_q <= CAUSE_OK;
      wr_en_q      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_d || gnt_c) begin
            cur_req      <= sel_req;
            label_q      <= gnt_c;
            inst_valid_q <= 1'b1;
            tran_vld_q   <= 1'b1;
            if (needs_wren(sel_req.inst)) begin
              tran_q <= WREN_REQ;
              state  <= ST_WREN_REQ;
            end else begin
              tran_q <= sel_req;
              state  <= ST_CMD_REQ;
            end
          end
        end
        ST_WREN_REQ, ST_CMD_REQ: begin
          if (io_tran_req_ready) begin
            tran_vld_q <= 1'b0;
            wait_cnt   <= 16'd0;
            state      <= (state == ST_WREN_REQ) ? ST_WREN_WAIT : ST_CMD_WAIT;
          end
        end
        ST_WREN_WAIT, ST_CMD_WAIT: begin
          if (end_op) begin
            // dchan errors are reported by the transfer level, so dchan just goes idle.
            if (label_q == CHAN_CCHAN) begin
              resp_vld_q   <= 1'b1;
              resp_err_q   <= (end_cause != CAUSE_OK);
              resp_cause_q <= end_cause;
              state        <= ST_RESP;
            end else begin
              inst_valid_q <= 1'b0;
              state        <= ST_IDLE;
            end
          end else if (state == ST_WREN_WAIT && io_tran_done) begin
            wr_en_q    <= 1'b1;
            tran_vld_q <= 1'b1;
            tran_q     <= cur_req;
            state      <= ST_CMD_REQ;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_RESP: begin
          inst_valid_q <= 1'b0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign io_dchan_req_ready     = gnt_d;
  assign io_cchan_req_ready     = gnt_c;
  assign io_tran_req_valid      = tran_vld_q;
  assign io_tran_req_inst       = tran_q.inst;
  assign io_tran_req_size       = tran_q.size;
  assign io_tran_req_burstlen   = tran_q.burstlen;
  assign io_tran_req_addr       = tran_q.addr;
  assign io_cchan_resp_valid    = resp_vld_q;
  assign io_cchan_resp_error    = resp_err_q;
  assign io_cchan_resp_cause    = resp_cause_q;
  assign io_ctrl_lev_inst_label = label_q;
  assign io_ctrl_lev_inst_valid = inst_valid_q;
  assign io_ctrl_lev_wr_en      = wr_en_q;

endmodule

// File: tb/tb_qspi_ctrl_req_arbiter.sv
// Self-checking bench for qspi_ctrl_req_arbiter: op table plus hand-built corner sequences.
// Transfer-level requests and cchan responses are checked against queued expectations.
// The bench plays the transfer level: accepts each request, then pulses done/error.
module tb_qspi_ctrl_req_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_dchan_req_valid, io_dchan_req_ready;
  logic [7:0]  io_dchan_req_data_size, io_dchan_req_data_burstlen, io_dchan_req_inst;
  logic [23:0] io_dchan_req_addr;
  logic        io_cchan_req_valid, io_cchan_req_ready;
  logic [7:0]  io_cchan_req_data_size, io_cchan_req_data_burstlen, io_cchan_req_inst;
  logic [23:0] io_cchan_req_addr;
  logic        io_tdata_lock;
  logic        io_cchan_resp_valid, io_cchan_resp_error;
  logic [1:0]  io_cchan_resp_cause;
  logic        io_tran_req_valid, io_tran_req_ready;
  logic [7:0]  io_tran_req_inst, io_tran_req_size, io_tran_req_burstlen;
  logic [23:0] io_tran_req_addr;
  logic        io_tran_done, io_tran_error;
  logic        io_ctrl_lev_inst_label, io_ctrl_lev_inst_valid, io_ctrl_lev_wr_en;

  always #5 clock = ~clock;

  qspi_ctrl_req_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .io_dchan_req_valid(io_dchan_req_valid), .io_dchan_req_ready(io_dchan_req_ready),
    .io_dchan_req_data_size(io_dchan_req_data_size),
    .io_dchan_req_data_burstlen(io_dchan_req_data_burstlen),
    .io_dchan_req_inst(io_dchan_req_inst), .io_dchan_req_addr(io_dchan_req_addr),
    .io_cchan_req_valid(io_cchan_req_valid), .io_cchan_req_ready(io_cchan_req_ready),
    .io_cchan_req_data_size(io_cchan_req_data_size),
    .io_cchan_req_data_burstlen(io_cchan_req_data_burstlen),
    .io_cchan_req_inst(io_cchan_req_inst), .io_cchan_req_addr(io_cchan_req_addr),
    .io_tdata_lock(io_tdata_lock),
    .io_cchan_resp_valid(io_cchan_resp_valid), .io_cchan_resp_error(io_cchan_resp_error),
    .io_cchan_resp_cause(io_cchan_resp_cause),
    .io_tran_req_valid(io_tran_req_valid), .io_tran_req_ready(io_tran_req_ready),
    .io_tran_req_inst(io_tran_req_inst), .io_tran_req_size(io_tran_req_size),
    .io_tran_req_burstlen(io_tran_req_burstlen), .io_tran_req_addr(io_tran_req_addr),
    .io_tran_done(io_tran_done), .io_tran_error(io_tran_error),
    .io_ctrl_lev_inst_label(io_ctrl_lev_inst_label),
    .io_ctrl_lev_inst_valid(io_ctrl_lev_inst_valid),
    .io_ctrl_lev_wr_en(io_ctrl_lev_wr_en)
  );

  typedef struct {
    logic [7:0]  inst;
    logic [23:0] addr;
    logic [7:0]  size;
    logic [7:0]  burst;
  } tran_exp_t;

  typedef struct {
    logic       err;
    logic [1:0] cause;
  } resp_exp_t;

  typedef struct {
    logic        chan;      // 0 = dchan, 1 = cchan
    logic [7:0]  inst;
    logic [23:0] addr;
    logic [7:0]  size;
    logic [7:0]  burst;
    logic        wren_err;  // transfer level fails the WREN
    logic        cmd_err;   // transfer level fails the command
    logic        exp_wren;  // WREN expected on tran
    logic        exp_cmd;   // command expected on tran
    logic        exp_err;
    logic [1:0]  exp_cause;
  } op_t;

  int        n_tests = 0;
  int        n_fail  = 0;
  int        wr_cnt  = 0;
  tran_exp_t sb_tran[$];
  resp_exp_t sb_resp[$];
  tran_exp_t mon_t;
  resp_exp_t mon_r;
  op_t       ops[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard pop side: compare every issued tran request and every cchan response.
  always @(negedge clock) begin
    if (io_tran_req_valid && io_tran_req_ready) begin
      if (sb_tran.size() == 0) begin
        check("tran_unexpected", {24'h0, io_tran_req_inst}, 32'hFFFF_FFFF);
      end else begin
        mon_t = sb_tran.pop_front();
        check("tran_inst", io_tran_req_inst, mon_t.inst);
        check("tran_addr", io_tran_req_addr, mon_t.addr);
        check("tran_size", io_tran_req_size, mon_t.size);
        check("tran_burst", io_tran_req_burstlen, mon_t.burst);
      end
    end
    if (io_cchan_resp_valid) begin
      if (sb_resp.size() == 0) begin
        check("resp_unexpected", io_cchan_resp_valid, 1'b0);
      end else begin
        mon_r = sb_resp.pop_front();
        check("resp_error", io_cchan_resp_error, mon_r.err);
        check("resp_cause", io_cchan_resp_cause, mon_r.cause);
      end
    end
    if (io_ctrl_lev_wr_en) wr_cnt++;
  end

  task automatic push_tran(input logic [7:0] inst, input logic [23:0] addr,
                           input logic [7:0] size, input logic [7:0] burst);
    sb_tran.push_back('{inst: inst, addr: addr, size: size, burst: burst});
  endtask

  task automatic push_resp(input logic err, input logic [1:0] cause);
    sb_resp.push_back('{err: err, cause: cause});
  endtask

  task automatic drive_chan(input logic chan, input logic vld, input logic [7:0] inst,
                            input logic [23:0] addr, input logic [7:0] size, input logic [7:0] burst);
    if (chan) begin
      io_cchan_req_valid = vld; io_cchan_req_inst = inst; io_cchan_req_addr = addr;
      io_cchan_req_data_size = size; io_cchan_req_data_burstlen = burst;
    end else begin
      io_dchan_req_valid = vld; io_dchan_req_inst = inst; io_dchan_req_addr = addr;
      io_dchan_req_data_size = size; io_dchan_req_data_burstlen = burst;
    end
  endtask

  // Wait (bounded) for the request's ready, then drop valid just after the accepting edge.
  task automatic accept_wait(input logic chan, input string tag);
    int   n = 0;
    logic rdy = 1'b0;
    while (!rdy && n < 20) begin
      @(negedge clock);
      rdy = chan ? io_cchan_req_ready : io_dchan_req_ready;
      n++;
    end
    check({tag, "_ready"}, rdy, 1'b1);
    @(posedge clock);
    #1;
    if (chan) io_cchan_req_valid = 1'b0;
    else      io_dchan_req_valid = 1'b0;
  endtask

  task automatic wait_tran_valid(input string tag, output logic ok);
    int n = 0;
    while (!io_tran_req_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    ok = io_tran_req_valid;
    check({tag, "_tran_valid"}, io_tran_req_valid, 1'b1);
  endtask

  // Transfer-level model: accept the pending request, then optionally pulse done.
  task automatic serve(input string tag, input logic do_done, input logic err);
    logic ok;
    wait_tran_valid(tag, ok);
    if (ok) begin
      @(posedge clock); #1 io_tran_req_ready = 1'b1;
      @(posedge clock); #1 io_tran_req_ready = 1'b0;
      if (do_done) begin
        repeat (2) @(posedge clock);
        #1 io_tran_done = 1'b1; io_tran_error = err;
        @(posedge clock);
        #1 io_tran_done = 1'b0; io_tran_error = 1'b0;
      end
    end
  endtask

  task automatic do_op(input op_t op, input string tag);
    int n;
    int wr0 = wr_cnt;
    if (op.exp_wren) push_tran(8'h06, 24'h0, 8'h0, 8'h0);
    if (op.exp_cmd)  push_tran(op.inst, op.addr, op.size, op.burst);
    if (op.chan)     push_resp(op.exp_err, op.exp_cause);
    drive_chan(op.chan, 1'b1, op.inst, op.addr, op.size, op.burst);
    accept_wait(op.chan, tag);
    @(negedge clock);
    check({tag, "_accept_to_valid"}, io_tran_req_valid, 1'b1);
    check({tag, "_first_inst"}, io_tran_req_inst, op.exp_wren ? 8'h06 : op.inst);
    check({tag, "_label"}, io_ctrl_lev_inst_label, op.chan);
    check({tag, "_inst_valid"}, io_ctrl_lev_inst_valid, 1'b1);
    if (op.exp_wren) begin
      serve({tag, "_wren"}, 1'b1, op.wren_err);
      if (!op.wren_err) begin
        @(negedge clock);
        check({tag, "_cmd_after_wren"}, io_tran_req_valid, 1'b1);
        check({tag, "_wr_en_with_cmd"}, io_ctrl_lev_wr_en, 1'b1);
      end
    end
    if (op.exp_cmd) serve({tag, "_cmd"}, 1'b1, op.cmd_err);
    if (op.chan) begin
      @(negedge clock);
      check({tag, "_done_to_resp"}, io_cchan_resp_valid, 1'b1);
    end
    n = 0;
    while (io_ctrl_lev_inst_valid && n < 10) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_back_idle"}, io_ctrl_lev_inst_valid, 1'b0);
    check({tag, "_wr_en_pulses"}, wr_cnt - wr0, (op.exp_wren && !op.wren_err) ? 1 : 0);
    check({tag, "_tran_drained"}, sb_tran.size(), 0);
    check({tag, "_resp_drained"}, sb_resp.size(), 0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int   k, wr0;
    logic ch;
    //           chan  inst    addr        size   burst  werr  cerr  W     C     err   cause
    ops[0] = '{1'b1, 8'h05, 24'h000000, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
    ops[1] = '{1'b0, 8'h02, 24'h001000, 8'h04, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00};
    ops[2] = '{1'b1, 8'hD8, 24'h020000, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11};
    ops[3] = '{1'b1, 8'h03, 24'h000100, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10};
    ops[4] = '{1'b1, 8'h20, 24'h003000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00};
    ops[5] = '{1'b0, 8'h0B, 24'h004000, 8'h20, 8'h07, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00};
    ops[6] = '{1'b0, 8'hC7, 24'h000000, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
    ops[7] = '{1'b1, 8'h01, 24'h000000, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00};

    reset = 1'b1;
    io_tdata_lock = 1'b0; io_tran_req_ready = 1'b0; io_tran_done = 1'b0; io_tran_error = 1'b0;
    drive_chan(1'b0, 1'b0, 8'h0, 24'h0, 8'h0, 8'h0);
    drive_chan(1'b1, 1'b0, 8'h0, 24'h0, 8'h0, 8'h0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_tran_valid", io_tran_req_valid, 1'b0);
    check("rst_tran_inst", io_tran_req_inst, 8'h0);
    check("rst_tran_addr", io_tran_req_addr, 24'h0);
    check("rst_tran_size", io_tran_req_size, 8'h0);
    check("rst_tran_burst", io_tran_req_burstlen, 8'h0);
    check("rst_resp_valid", io_cchan_resp_valid, 1'b0);
    check("rst_resp_error", io_cchan_resp_error, 1'b0);
    check("rst_resp_cause", io_cchan_resp_cause, 2'b00);
    check("rst_inst_valid", io_ctrl_lev_inst_valid, 1'b0);
    check("rst_label", io_ctrl_lev_inst_label, 1'b0);
    check("rst_wr_en", io_ctrl_lev_wr_en, 1'b0);
    check("rst_dchan_ready", io_dchan_req_ready, 1'b0);
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 8; i++) do_op(ops[i], $sformatf("op%0d", i));

    // Timeout: cchan 0x9F never completes; response lands 16 cycles after entering CMD_WAIT.
    push_tran(8'h9F, 24'h000000, 8'h03, 8'h00);
    push_resp(1'b1, 2'b01);
    drive_chan(1'b1, 1'b1, 8'h9F, 24'h000000, 8'h03, 8'h00);
    accept_wait(1'b1, "tmo");
    serve("tmo", 1'b0, 1'b0);
    k = 0;
    do begin
      @(posedge clock); #1;
      k++;
    end while (!io_cchan_resp_valid && k < 40);
    check("tmo_cycles", k, 16);
    check("tmo_resp_error", io_cchan_resp_error, 1'b1);
    check("tmo_resp_cause", io_cchan_resp_cause, 2'b01);
    repeat (2) @(posedge clock); #1;

    // Done arriving on the very cycle the timeout would fire: done wins.
    push_tran(8'h9F, 24'h000010, 8'h03, 8'h00);
    push_resp(1'b0, 2'b00);
    drive_chan(1'b1, 1'b1, 8'h9F, 24'h000010, 8'h03, 8'h00);
    accept_wait(1'b1, "race");
    serve("race", 1'b0, 1'b0);
    repeat (15) @(posedge clock);
    #1 io_tran_done = 1'b1;
    @(posedge clock);
    #1 io_tran_done = 1'b0;
    check("race_resp_valid", io_cchan_resp_valid, 1'b1);
    check("race_resp_cause", io_cchan_resp_cause, 2'b00);
    repeat (2) @(posedge clock); #1;

    // Round-robin from reset with both channels always valid.
    reset = 1'b1;
    @(posedge clock); @(posedge clock); #1 reset = 1'b0;
    wr0 = wr_cnt;
    drive_chan(1'b1, 1'b1, 8'h05, 24'h000AAA, 8'h01, 8'h00);
    drive_chan(1'b0, 1'b1, 8'h03, 24'h000555, 8'h08, 8'h01);
    for (int i = 0; i < 8; i++) begin
      logic ok;
      ch = (i % 2 == 0);
      if (ch) begin
        push_tran(8'h05, 24'h000AAA, 8'h01, 8'h00);
        push_resp(1'b0, 2'b00);
      end else begin
        push_tran(8'h03, 24'h000555, 8'h08, 8'h01);
      end
      wait_tran_valid($sformatf("rr%0d", i), ok);
      check($sformatf("rr%0d_label", i), io_ctrl_lev_inst_label, ch);
      serve($sformatf("rr%0d", i), 1'b1, 1'b0);
    end
    io_cchan_req_valid = 1'b0; io_dchan_req_valid = 1'b0;

    // tdata_lock holds dchan off; releasing it lets dchan win the next tie.
    io_tdata_lock = 1'b1;
    io_cchan_req_valid = 1'b1; io_dchan_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic ok;
      ch = (i < 3);
      if (ch) begin
        push_tran(8'h05, 24'h000AAA, 8'h01, 8'h00);
        push_resp(1'b0, 2'b00);
      end else begin
        push_tran(8'h03, 24'h000555, 8'h08, 8'h01);
      end
      wait_tran_valid($sformatf("lock%0d", i), ok);
      check($sformatf("lock%0d_label", i), io_ctrl_lev_inst_label, ch);
      serve($sformatf("lock%0d", i), 1'b1, 1'b0);
      if (i == 2) io_tdata_lock = 1'b0;
    end
    io_cchan_req_valid = 1'b0; io_dchan_req_valid = 1'b0;
    repeat (3) @(posedge clock); #1;
    check("rr_wr_en_none", wr_cnt - wr0, 0);
    check("rr_tran_drained", sb_tran.size(), 0);
    check("rr_resp_drained", sb_resp.size(), 0);

    // Reset while parked in CMD_WAIT: everything clears, no response, next op normal.
    push_tran(8'h9F, 24'h123456, 8'h02, 8'h00);
    drive_chan(1'b1, 1'b1, 8'h9F, 24'h123456, 8'h02, 8'h00);
    accept_wait(1'b1, "rstmid");
    serve("rstmid", 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    check("rstmid_tran_valid", io_tran_req_valid, 1'b0);
    check("rstmid_tran_inst", io_tran_req_inst, 8'h0);
    check("rstmid_tran_addr", io_tran_req_addr, 24'h0);
    check("rstmid_inst_valid", io_ctrl_lev_inst_valid, 1'b0);
    check("rstmid_label", io_ctrl_lev_inst_label, 1'b0);
    check("rstmid_resp_valid", io_cchan_resp_valid, 1'b0);
    reset = 1'b0;
    @(posedge clock); #1;
    do_op(ops[0], "post_rst");

    check("final_tran_drained", sb_tran.size(), 0);
    check("final_resp_drained", sb_resp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
